sme_scan_engine: RTL and testbench

//  Parametrised string-match engine that succeeds the contest SME.
//  - Serially loads one string, then any number of patterns against it.
//  - Supports ^ $ . * and reports the leftmost match per pattern.
//  - Scans one alignment per cycle with PAT_MAX parallel comparators, instead of all alignments at once.
//  - Sits between the byte-stream test interface and the result checker.

---
 rtl/sme_pkg.sv | 24 ++
 rtl/sme_window_cmp.sv | 49 ++++
 rtl/sme_scan_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_sme_scan_engine.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared character codes and FSM encoding for the SME scan engine.
// Defining SME_STAR_EN adds the SCAN2 state used by single-star patterns.
package sme_pkg;

    localparam logic [7:0] CH_HEAD  = 8'h5E;
    localparam logic [7:0] CH_TAIL  = 8'h24;
    localparam logic [7:0] CH_ANY   = 8'h2E;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LD_STR,
        LD_PAT,
        PREP,
        SCAN,
`ifdef SME_STAR_EN
        SCAN2,
`endif
        DONE,
        WAIT
    } sme_state_t;

endpackage

// File: rtl/sme_window_cmp.sv
// Combinational comparison of one pattern segment against the string at one
// alignment; ^ and $ are zero-width, so each pattern char maps to a running position.
module sme_window_cmp
    import sme_pkg::*;
#(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = $clog2(STR_MAX + 1),
    parameter int PCNT_W  = $clog2(PAT_MAX + 1)
) (
    input  logic [STR_MAX*8-1:0] str_flat,
    input  logic [CNT_W-1:0]     str_len,
    input  logic [CNT_W-1:0]     pos_start,
    input  logic [PAT_MAX*8-1:0] pat_flat,
    input  logic [PCNT_W-1:0]    pat_len,
    output logic                 hit,
    output logic [PCNT_W-1:0]    consumed
);

    // Shifting out of range yields 0, so no explicit bounds guard is needed.
    function automatic logic [7:0] str_char(input logic [STR_MAX*8-1:0] flat, input int p);
        return 8'(flat >> (8 * p));
    endfunction

    always_comb begin
        int pos;
        int len;
        logic [7:0] c;
        hit = 1'b1;
        pos = int'(pos_start);
        len = int'(str_len);
        c   = 8'h00;
        for (int k = 0; k < PAT_MAX; k++) begin
            c = 8'(pat_flat >> (8 * k));
            if (k < int'(pat_len)) begin
                if (c == CH_HEAD) begin
                    if (pos != 0 && str_char(str_flat, pos - 1) != CH_SPACE) hit = 1'b0;
                end else if (c == CH_TAIL) begin
                    if (pos != len && str_char(str_flat, pos) != CH_SPACE) hit = 1'b0;
                end else begin
                    if (pos >= len || (c != CH_ANY && str_char(str_flat, pos) != c)) hit = 1'b0;
                    pos = pos + 1;
                end
            end
        end
        consumed = PCNT_W'(pos - int'(pos_start));
    end

endmodule

// File: rtl/sme_scan_engine.sv
// Serial string/pattern loader with a one-alignment-per-cycle scanner.
// Optional feature macro: SME_STAR_EN (single * with prefix scan then suffix scan).
module sme_scan_engine
    import sme_pkg::*;
#(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDX_W   = $clog2(STR_MAX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    output logic             busy,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index
);

    localparam int CNT_W   = $clog2(STR_MAX + 1);
    localparam int PCNT_W  = $clog2(PAT_MAX + 1);
    localparam int SIDX_W  = $clog2(STR_MAX);
    localparam int PIDX_W  = $clog2(PAT_MAX);

    sme_state_t state_reg, state_next;

    logic [7:0]           str_mem [STR_MAX];
    logic [7:0]           pat_mem [PAT_MAX];
    logic [CNT_W-1:0]     str_len_reg;
    logic [PCNT_W-1:0]    pat_len_reg;
    logic [CNT_W-1:0]     pos_reg;
    logic                 match_reg;
    logic [IDX_W-1:0]     idx_reg;

    logic                 str_clr, str_we, pat_clr, pat_we;
    logic [CNT_W-1:0]     str_wr_base;
    logic [PCNT_W-1:0]    pat_wr_base;
    logic                 str_room, pat_room;
    logic [STR_MAX*8-1:0] str_flat;
    logic [PAT_MAX*8-1:0] pat_flat;
    logic [PAT_MAX*8-1:0] seg_flat;
    logic [PCNT_W-1:0]    seg_len;
    logic                 win_hit;
    logic [PCNT_W-1:0]    win_len;
    logic                 at_end;

    for (genvar gi = 0; gi < STR_MAX; gi++) begin : g_str_flat
        assign str_flat[8*gi +: 8] = str_mem[gi];
    end

    for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_pat_flat
        assign pat_flat[8*gi +: 8] = pat_mem[gi];
    end

    assign at_end      = (pos_reg == str_len_reg);
    assign str_wr_base = str_clr ? '0 : str_len_reg;
    assign pat_wr_base = pat_clr ? '0 : pat_len_reg;
    assign str_room    = (str_wr_base < CNT_W'(STR_MAX));
    assign pat_room    = (pat_wr_base < PCNT_W'(PAT_MAX));

`ifdef SME_STAR_EN
    logic              has_star_reg;
    logic [PCNT_W-1:0] star_pos_reg;
    logic [CNT_W-1:0]  pfx_pos_reg;
    logic              star_found;
    logic [PCNT_W-1:0] star_at;

    // Scan downward so the first * in the pattern wins.
    always_comb begin
        star_found = 1'b0;
        star_at    = '0;
        for (int k = PAT_MAX - 1; k >= 0; k--) begin
            if (k < int'(pat_len_reg) && 8'(pat_flat >> (8 * k)) == CH_STAR) begin
                star_found = 1'b1;
                star_at    = PCNT_W'(k);
            end
        end
    end

    always_comb begin
        seg_flat = pat_flat;
        seg_len  = has_star_reg ? star_pos_reg : pat_len_reg;
        if (state_reg == SCAN2) begin
            seg_flat = pat_flat >> (8 * (int'(star_pos_reg) + 1));
            seg_len  = pat_len_reg - star_pos_reg - PCNT_W'(1);
        end
    end
`else
    logic win_len_unused;

    assign seg_flat       = pat_flat;
    assign seg_len        = pat_len_reg;
    assign win_len_unused = ^win_len;
`endif

    sme_window_cmp #(
        .STR_MAX (STR_MAX),
        .PAT_MAX (PAT_MAX),
        .CNT_W   (CNT_W),
        .PCNT_W  (PCNT_W)
    ) u_window_cmp (
        .str_flat  (str_flat),
        .str_len   (str_len_reg),
        .pos_start (pos_reg),
        .pat_flat  (seg_flat),
        .pat_len   (seg_len),
        .hit       (win_hit),
        .consumed  (win_len)
    );

    // Pattern bytes are accepted in IDLE too, so the post-reset empty string is searchable.
    always_comb begin
        state_next = state_reg;
        str_clr    = 1'b0;
        str_we     = 1'b0;
        pat_clr    = 1'b0;
        pat_we     = 1'b0;
        case (state_reg)
            IDLE, WAIT: begin
                if (isstring) begin
                    str_clr    = 1'b1;
                    str_we     = 1'b1;
                    state_next = LD_STR;
                end else if (ispattern) begin
                    pat_clr    = 1'b1;
                    pat_we     = 1'b1;
                    state_next = LD_PAT;
                end
            end
            LD_STR: begin
                if (isstring) begin
                    str_we = 1'b1;
                end else if (ispattern) begin
                    pat_clr    = 1'b1;
                    pat_we     = 1'b1;
                    state_next = LD_PAT;
                end
            end
            LD_PAT: begin
                if (ispattern && !isstring) pat_we = 1'b1;
                else state_next = PREP;
            end
            PREP: state_next = SCAN;
            SCAN: begin
                if (win_hit) begin
`ifdef SME_STAR_EN
                    state_next = has_star_reg ? SCAN2 : DONE;
`else
                    state_next = DONE;
`endif
                end else if (at_end) begin
                    state_next = DONE;
                end
            end
`ifdef SME_STAR_EN
            SCAN2: if (win_hit || at_end) state_next = DONE;
`endif
            DONE:    state_next = WAIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (str_we && str_room) str_mem[SIDX_W'(str_wr_base)] <= chardata;
        if (pat_we && pat_room) pat_mem[PIDX_W'(pat_wr_base)] <= chardata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            str_len_reg <= '0;
            pat_len_reg <= '0;
            pos_reg     <= '0;
            match_reg   <= 1'b0;
            idx_reg     <= '0;
`ifdef SME_STAR_EN
            has_star_reg <= 1'b0;
            star_pos_reg <= '0;
            pfx_pos_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (str_we) str_len_reg <= str_room ? str_wr_base + CNT_W'(1) : str_wr_base;
            if (pat_we) pat_len_reg <= pat_room ? pat_wr_base + PCNT_W'(1) : pat_wr_base;
            case (state_reg)
                PREP: begin
                    pos_reg   <= '0;
                    match_reg <= 1'b0;
                    idx_reg   <= '0;
`ifdef SME_STAR_EN
                    has_star_reg <= star_found;
                    star_pos_reg <= star_at;
`endif
                end
                SCAN: begin
                    if (win_hit) begin
`ifdef SME_STAR_EN
                        if (has_star_reg) begin
                            // Earliest prefix hit is final; the suffix search starts right after it.
                            pfx_pos_reg <= pos_reg;
                            pos_reg     <= pos_reg + CNT_W'(win_len);
                        end else begin
                            match_reg <= 1'b1;
                            idx_reg   <= IDX_W'(pos_reg);
                        end
`else
                        match_reg <= 1'b1;
                        idx_reg   <= IDX_W'(pos_reg);
`endif
                    end else if (!at_end) begin
                        pos_reg <= pos_reg + CNT_W'(1);
                    end
                end
`ifdef SME_STAR_EN
                SCAN2: begin
                    if (win_hit) begin
                        match_reg <= 1'b1;
                        idx_reg   <= IDX_W'(pfx_pos_reg);
                    end else if (!at_end) begin
                        pos_reg <= pos_reg + CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state_reg == PREP) || (state_reg == SCAN);
`ifdef SME_STAR_EN
        busy = busy || (state_reg == SCAN2);
`endif
    end

    assign valid       = (state_reg == DONE);
    assign match       = valid & match_reg;
    assign match_index = valid ? idx_reg : '0;

endmodule

// File: tb/tb_sme_scan_engine.sv
// Scoreboard bench for sme_scan_engine: a string-level reference model predicts each
// result, a negedge monitor pops and compares on every valid strobe.
module tb_sme_scan_engine;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int IDX_W   = $clog2(STR_MAX);

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       chardata;
    logic             isstring;
    logic             ispattern;
    logic             busy;
    logic             valid;
    logic             match;
    logic [IDX_W-1:0] match_index;

    always #5 clk = ~clk;

    sme_scan_engine #(
        .STR_MAX (STR_MAX),
        .PAT_MAX (PAT_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .busy        (busy),
        .valid       (valid),
        .match       (match),
        .match_index (match_index)
    );

    typedef struct {
        bit    m;
        int    idx;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    int    errors  = 0;
    int    checks  = 0;
    int    n_valid = 0;
    string cur_str = "";
    bit    star_en;

    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Does pattern chars [lo,hi) match string s starting at position start?
    function automatic bit seg_match(string s, string p, int lo, int hi, int start, output int endpos);
        int  pos;
        byte c;
        pos    = start;
        endpos = start;
        for (int k = lo; k < hi; k++) begin
            c = p[k];
            if (c == "^") begin
                if (!(pos == 0 || s[pos-1] == " ")) return 1'b0;
            end else if (c == "$") begin
                if (!(pos == s.len() || s[pos] == " ")) return 1'b0;
            end else begin
                if (pos >= s.len()) return 1'b0;
                if (c != "." && s[pos] != c) return 1'b0;
                pos++;
            end
        end
        endpos = pos;
        return 1'b1;
    endfunction

    function automatic void model(string s_in, string p_in, output bit m, output int idx);
        string s;
        string p;
        int    star;
        int    e1;
        int    e2;
        s    = (s_in.len() > STR_MAX) ? s_in.substr(0, STR_MAX - 1) : s_in;
        p    = (p_in.len() > PAT_MAX) ? p_in.substr(0, PAT_MAX - 1) : p_in;
        m    = 1'b0;
        idx  = 0;
        star = -1;
        if (star_en) begin
            for (int k = p.len() - 1; k >= 0; k--) if (p[k] == "*") star = k;
        end
        for (int st = 0; st <= s.len(); st++) begin
            if (star < 0) begin
                if (seg_match(s, p, 0, p.len(), st, e1)) begin
                    m   = 1'b1;
                    idx = st;
                    return;
                end
            end else if (seg_match(s, p, 0, star, st, e1)) begin
                for (int q = e1; q <= s.len(); q++) begin
                    if (seg_match(s, p, star + 1, p.len(), q, e2)) begin
                        m   = 1'b1;
                        idx = st;
                        return;
                    end
                end
                return;
            end
        end
    endfunction

    // Monitor: one line per result, compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n_valid++;
                check("expect_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("txn %s: match=%0d idx=%0d (want %0d/%0d)",
                             e.tag, match, match_index, e.m, e.idx % (1 << IDX_W));
                    check({e.tag, " match"}, int'(match), int'(e.m));
                    check({e.tag, " idx"}, int'(match_index), e.idx % (1 << IDX_W));
                end
            end
        end
    end

    task automatic send_string(string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk); #1;
            isstring = 1'b1;
            chardata = s[i];
        end
        @(posedge clk); #1;
        isstring = 1'b0;
        chardata = 8'h00;
        cur_str  = s;
    endtask

    task automatic send_pattern_bytes(string p);
        for (int i = 0; i < p.len(); i++) begin
            @(posedge clk); #1;
            ispattern = 1'b1;
            chardata  = p[i];
        end
        @(posedge clk); #1;
        ispattern = 1'b0;
        chardata  = 8'h00;
    endtask

    task automatic run_pattern(string p, string tag);
        exp_t e;
        int   base;
        int   lim;
        int   len;
        int   cyc;
        model(cur_str, p, e.m, e.idx);
        e.tag = tag;
        exp_q.push_back(e);
        base = n_valid;
        len  = (cur_str.len() > STR_MAX) ? STR_MAX : cur_str.len();
        lim  = 3 + len + (star_en ? len : 0);
        send_pattern_bytes(p);
        cyc = 0;
        while (n_valid == base && cyc < lim + 10) begin
            @(negedge clk); #1;
            cyc++;
        end
        check({tag, " valid_seen"}, n_valid - base, 1);
        check({tag, " latency_ok"}, int'(cyc - 2 <= lim), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset     = 1'b1;
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = 8'h00;
        @(posedge clk); #1;
        reset   = 1'b0;
        cur_str = "";
    endtask

    function automatic string rand_text(string alph, int n, int star_k);
        string r;
        r = "";
        for (int k = 0; k < n; k++) begin
            if (k == star_k) r = $sformatf("%s*", r);
            else r = $sformatf("%s%c", r, alph[$urandom_range(0, alph.len() - 1)]);
        end
        return r;
    endfunction

    initial begin
        string s_alph;
        string p_alph;
        string p;
        int    base;
`ifdef SME_STAR_EN
        star_en = 1'b1;
`else
        star_en = 1'b0;
`endif
        s_alph    = "ab c*";
        p_alph    = "ab .^$";
        reset     = 1'b1;
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = 8'h00;
        repeat (3) @(posedge clk);
        do_reset();
        check("reset valid", int'(valid), 0);
        check("reset match", int'(match), 0);
        check("reset idx", int'(match_index), 0);
        check("reset busy", int'(busy), 0);

        // Empty string straight after reset.
        run_pattern("^$", "empty ^$");
        run_pattern("$", "empty $");
        run_pattern("a", "empty a");
        run_pattern("*", "empty *");

        send_string("hello world");
        run_pattern("wor", "hw wor");
        run_pattern("^wor", "hw ^wor");
        run_pattern("llo$", "hw llo$");
        run_pattern("lo$", "hw lo$");
        run_pattern("^h.l", "hw ^h.l");
        run_pattern("d$", "hw d$");

        send_string("abc");
        run_pattern("^$", "abc ^$");
        run_pattern("abcd", "abc abcd");

        send_string("the cat sat");
        run_pattern("c*t", "cat c*t");
        run_pattern("z*t", "cat z*t");
        run_pattern("*", "cat *");
        run_pattern("s*$", "cat s*$");

        // 34 chars sent; the last two are dropped.
        send_string("abcdefghijklmnopqrstuvwxyzABCDEFGH");
        run_pattern(".", "long .");
        run_pattern("F$", "long F$");
        run_pattern("G", "long G");
        run_pattern("abcdefghij", "long trunc_pat");

        send_string("ab");
        run_pattern("ab", "ab ab");
        run_pattern("b", "ab b");

        // Abort a scan with reset: no result may ever appear.
        send_string("abcdefghijklmnopqrstuvwxyzABCDEF");
        base = n_valid;
        send_pattern_bytes("zz");
        repeat (4) @(posedge clk);
        #1;
        check("midscan busy", int'(busy), 1);
        do_reset();
        check("abort valid", int'(valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort match", int'(match), 0);
        repeat (50) @(posedge clk);
        #1;
        check("abort no_valid", n_valid - base, 0);

        for (int it = 0; it < 60; it++) begin
            if (it == 0 || $urandom_range(0, 2) == 0)
                send_string(rand_text(s_alph, $urandom_range(1, 34), -1));
            if ($urandom_range(0, 1) == 1) p = rand_text(p_alph, $urandom_range(1, 9), -1);
            else begin
                int n;
                n = $urandom_range(1, 9);
                p = rand_text(p_alph, n, $urandom_range(0, n - 1));
            end
            run_pattern(p, $sformatf("rnd%0d", it));
        end

        repeat (3) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
